latch_wr_ctrl: RTL and testbench
================================

Name: latch_wr_ctrl

Overview:
Clocked write controller that drives the D/En gate interface of a bank of level-sensitive D latches. It accepts (address, data) write requests over a valid/ready handshake and presents data on lat_d. It then opens exactly one latch enable, with guaranteed setup, open and hold windows counted in clock cycles. A shadow copy of each latch's committed value is kept for readback and for checking.

Parameters:
DATA_W, 8, width of latch data bus
NUM_LATCH, 4, number of latches in the bank; lat_en is one-hot over these
SETUP_CYC, 1, cycles lat_d is stable before the enable rises (>=1)
OPEN_CYC, 2, cycles the selected enable is high (>=1)
HOLD_CYC, 1, cycles lat_d is stable after the enable falls (>=1)

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  write request valid
in_ready  out  1  controller can accept a request (high only in IDLE)
in_addr  in  $clog2(NUM_LATCH) (min 1)  target latch index
in_data  in  DATA_W  value to write
lat_d  out  DATA_W  latch data bus, registered
lat_en  out  NUM_LATCH  latch enables, one-hot or zero, registered (glitch-free)
done  out  1  one-cycle pulse when a write completes
err  out  1  one-cycle pulse when a request had out-of-range address
shadow  out  NUM_LATCH*DATA_W  committed latch values, latch i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; lat_d=0, lat_en=0, done=0, err=0, shadow=0, phase counter=0. in_ready=1 once in IDLE.
- States: IDLE -> SETUP -> OPEN -> HOLD -> IDLE. in_ready = (state==IDLE).
- Acceptance:
  - A request is accepted on a rising edge where in_valid && in_ready.
  - If in_addr >= NUM_LATCH: no transition, err=1 next cycle, lat_d/lat_en unchanged.
  - Otherwise: latch addr/data into internal regs, lat_d<=in_data, go to SETUP with counter loaded.
- SETUP: lat_en=0, lat_d stable, for SETUP_CYC cycles, then OPEN.
- OPEN: lat_en = one-hot(addr) for exactly OPEN_CYC cycles, lat_d stable, then HOLD.
- HOLD: lat_en=0, lat_d stable, for HOLD_CYC cycles.
- Completion: on the edge leaving HOLD, shadow[addr]<=data and done=1 for that one IDLE cycle.
- Latency: the accept edge is cycle 0.
  - lat_d valid in cycles 1..S+O+H, where S/O/H are SETUP_CYC/OPEN_CYC/HOLD_CYC.
  - lat_en high in cycles S+1..S+O.
  - done in cycle S+O+H+1.
- Throughput: a new request may be accepted in the same cycle done is high (back-to-back). Period is S+O+H+1 cycles.
- lat_d holds its last value in IDLE and is never changed while any lat_en bit is high or within the hold window.
- At most one lat_en bit is ever high. lat_en is never high outside OPEN.
- in_valid/in_addr/in_data are ignored outside IDLE. The requester must hold them until accepted.
- Reset mid-operation:
  - lat_en drops to 0 asynchronously and shadow clears to 0; the transaction is lost with no done.
  - The physical latch content is then undefined; shadow is not guaranteed to match it.
- Counter width: $clog2(max(S,O,H)+1). It counts down to 1, and the phase ends when the count reaches 1.

Decomposition:
- Package latch_ctrl_pkg: state enum (IDLE, SETUP, OPEN, HOLD) and default timing constants.
- Sub-module phase_timer: loadable down-counter with load value and a "last" output. The FSM reloads it per phase.
- Shadow array and one-hot decode stay in the top module.

Test Plan:
- Reset then idle: release rst_n, hold in_valid=0 for 10 cycles -> in_ready=1, lat_en=0, lat_d=0, shadow=0, done/err never pulse.
- Single write with defaults: addr=1, data=8'hA5 accepted at cycle 0 -> lat_d=A5 from cycle 1, lat_en=4'b0010 in cycles 2-3 only, lat_en=0 in cycle 4, done=1 in cycle 5, shadow[15:8]=A5.
- Back-to-back: addr=0/8'h3C, then addr=3/8'hFF presented during done -> second accepted in cycle 5 with no gap, lat_en=0001 then 1000, never two bits set, both shadow entries correct.
- Out-of-range address: NUM_LATCH=3, addr=3, data=8'h11 -> err=1 one cycle, no lat_en, lat_d unchanged, stays IDLE.
- Reset mid-OPEN: assert rst_n low during cycle 2 -> lat_en=0 immediately (before the next edge), no done, shadow=0, in_ready=1 after release.
- Timing parameters: SETUP_CYC=3, OPEN_CYC=1, HOLD_CYC=2 -> lat_en high only in cycle 4, done in cycle 7, lat_d stable throughout cycles 1-6.

Source files
------------

// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg
//   Shared types and defaults for the latch write controller.
//   - state_t     : write sequencer phases (IDLE -> SETUP -> OPEN -> HOLD)
//   - DEF_*       : default bus sizes and setup/open/hold windows
//   - max3        : largest of three window lengths
//   - cnt_width   : phase counter width able to hold the longest window
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_LATCH = 4;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_OPEN_CYC  = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Width of a down-counter that must be loadable with any of the windows.
  function automatic int cnt_width(input int s, input int o, input int h);
    int w;
    w = $clog2(max3(s, o, h) + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer
//   Loadable down-counter used to time each phase of a latch write.
//   The sequencer loads the phase length on entry; the counter then steps
//   down and parks at 1. last_o is high in the final cycle of the phase.
//   Ports:
//     clk, rst_n   : clock, async active-low reset (count clears to 0)
//     load_i       : load load_val_i on the next rising edge
//     load_val_i   : phase length in cycles (0 parks the timer)
//     cnt_o        : current count
//     last_o       : count == 1, the phase ends on this cycle's edge
module phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/latch_wr_ctrl.sv
// latch_wr_ctrl
//   Write controller for a bank of level-sensitive D latches. A write request
//   (address, data) is taken over a valid/ready handshake, the data is driven
//   on lat_d, and the addressed latch enable is pulsed with guaranteed setup,
//   open and hold windows. A shadow copy of every committed value is kept.
//
//   Handshake: a request transfers on a rising edge where in_valid && in_ready.
//   in_ready is high only in IDLE; the requester holds in_valid/in_addr/in_data
//   steady until the transfer, and they are ignored in every other state.
//
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     in_valid/in_ready   : request handshake
//     in_addr, in_data    : target latch index and value
//     lat_d               : registered latch data bus
//     lat_en              : registered one-hot (or zero) latch enables
//     done                : one-cycle pulse after a write commits
//     err                 : one-cycle pulse after an out-of-range request
//     shadow              : committed values, latch i at [i*DATA_W +: DATA_W]
//     dbg_state           : current sequencer state
module latch_wr_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LATCH = DEF_NUM_LATCH,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int OPEN_CYC  = DEF_OPEN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int ADDR_W    = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_data,
  output logic [DATA_W-1:0]           lat_d,
  output logic [NUM_LATCH-1:0]        lat_en,
  output logic                        done,
  output logic                        err,
  output logic [NUM_LATCH*DATA_W-1:0] shadow,
  output logic [1:0]                  dbg_state
);

  localparam int CNT_W = cnt_width(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  state_t state_q, state_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W-1:0]    lat_d_q;
  logic [NUM_LATCH-1:0] lat_en_q, lat_en_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    shadow_q [NUM_LATCH];

  logic                 accept;
  logic                 addr_ok;
  logic                 commit;
  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic [CNT_W-1:0]     tmr_cnt;
  logic                 tmr_last;
  logic [NUM_LATCH-1:0] en_sel;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .cnt_o      (tmr_cnt),
    .last_o     (tmr_last)
  );

  assign addr_ok = (32'(in_addr) < NUM_LATCH);

  // Sequencer: next state, timer reload, and transfer/commit strobes.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    accept   = 1'b0;
    commit   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (addr_ok) begin
            accept   = 1'b1;
            state_d  = SETUP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(SETUP_CYC);
          end else begin
            // Bad address: flag it and stay put, bus untouched.
            err_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (tmr_last) begin
          state_d  = OPEN;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(OPEN_CYC);
        end
      end
      OPEN: begin
        if (tmr_last) begin
          state_d  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYC);
        end
      end
      HOLD: begin
        if (tmr_last) begin
          state_d  = IDLE;
          commit   = 1'b1;
          // Park the timer at 0 so last stays low while idle.
          tmr_load = 1'b1;
          tmr_val  = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One-hot decode of the captured address.
  always_comb begin
    en_sel = '0;
    for (int i = 0; i < NUM_LATCH; i++) begin
      en_sel[i] = (addr_q == ADDR_W'(i));
    end
  end

  // Enables are registered from the next state, so they change only on the
  // edge that enters or leaves OPEN and never glitch.
  always_comb begin
    lat_en_d = '0;
    if (state_d == OPEN) begin
      lat_en_d = en_sel;
    end
  end

  assign done_d = commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_en_q <= lat_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      // lat_d only moves on a transfer, which happens in IDLE, so it stays
      // frozen through setup, open and hold.
      if (accept) begin
        addr_q  <= in_addr;
        data_q  <= in_data;
        lat_d_q <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LATCH; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (commit) begin
      for (int i = 0; i < NUM_LATCH; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          shadow_q[i] <= data_q;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_LATCH; gi++) begin : g_shadow
    assign shadow[gi*DATA_W +: DATA_W] = shadow_q[gi];
  end

  assign in_ready  = (state_q == IDLE);
  assign lat_d     = lat_d_q;
  assign lat_en    = lat_en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_latch_wr_ctrl.sv
// tb_latch_wr_ctrl
//   Two controller instances share one clock and reset:
//     g_inst[0] : defaults (4 latches, setup 1 / open 2 / hold 1)
//     g_inst[1] : 3 latches, setup 3 / open 1 / hold 2 (address 3 is illegal)
//   Each instance has a request queue feeding a driver and a reference model
//   that predicts every output per cycle from the transaction's age.
module tb_latch_wr_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit gap_en   = 1'b0;

  logic [AW+DW-1:0] req_q [2][$];
  bit idle_m [2];
  bit open_m [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int N = (g == 0) ? 4 : 3;
    localparam int S = (g == 0) ? 1 : 3;
    localparam int O = (g == 0) ? 2 : 1;
    localparam int H = (g == 0) ? 1 : 2;
    localparam int P = S + O + H + 1;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_addr;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   lat_d;
    logic [N-1:0]    lat_en;
    logic            done;
    logic            err;
    logic [N*DW-1:0] shadow;
    logic [1:0]      dbg_state;

    latch_wr_ctrl #(
      .DATA_W    (DW),
      .NUM_LATCH (N),
      .SETUP_CYC (S),
      .OPEN_CYC  (O),
      .HOLD_CYC  (H)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .lat_d     (lat_d),
      .lat_en    (lat_en),
      .done      (done),
      .err       (err),
      .shadow    (shadow),
      .dbg_state (dbg_state)
    );

    // Reference model state: one outstanding transaction and its start cycle.
    bit            acc = 1'b0;
    bit            act = 1'b0;
    bit            err_pend = 1'b0;
    int            cyc = 0;
    int            st = 0;
    int            rel;
    logic [AW-1:0] ma = '0;
    logic [DW-1:0] md = '0;
    logic [DW-1:0] exp_d = '0;
    logic [DW-1:0] sh [N];
    logic [N-1:0]  en_x;
    logic [N*DW-1:0] sh_x;
    bit            rdy_x, done_x, err_x;

    // Driver: presents the next queued request and holds it until the model
    // says it transferred.
    initial begin
      logic [AW+DW-1:0] r;
      in_valid = 1'b0;
      in_addr  = '0;
      in_data  = '0;
      forever begin
        @(posedge clk);
        #1;
        if (acc) begin
          acc      = 1'b0;
          in_valid = 1'b0;
        end
        if (!in_valid && req_q[g].size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
          r = req_q[g].pop_front();
          {in_addr, in_data} = r;
          in_valid = 1'b1;
        end
      end
    end

    // Model and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
      if (!rst_n) begin
        act      = 1'b0;
        err_pend = 1'b0;
        exp_d    = '0;
        for (int i = 0; i < N; i++) sh[i] = '0;
      end
      rel    = cyc - st;
      rdy_x  = !(act && rel >= 1 && rel <= P - 1);
      en_x   = (act && rel >= S + 1 && rel <= S + O) ? (N'(1) << ma) : '0;
      done_x = act && (rel == P);
      err_x  = err_pend;
      if (done_x) sh[ma] = md;
      for (int i = 0; i < N; i++) sh_x[i*DW +: DW] = sh[i];
      open_m[g] = (en_x != '0);

      check($sformatf("g%0d_in_ready", g), 64'(in_ready), 64'(rdy_x));
      check($sformatf("g%0d_lat_d", g),    64'(lat_d),    64'(exp_d));
      check($sformatf("g%0d_lat_en", g),   64'(lat_en),   64'(en_x));
      check($sformatf("g%0d_done", g),     64'(done),     64'(done_x));
      check($sformatf("g%0d_err", g),      64'(err),      64'(err_x));
      check($sformatf("g%0d_shadow", g),   64'(shadow),   64'(sh_x));

      err_pend = 1'b0;
      if (done_x) act = 1'b0;
      if (rst_n && in_valid && rdy_x) begin
        acc = 1'b1;
        if (32'(in_addr) >= N) begin
          err_pend = 1'b1;
        end else begin
          act   = 1'b1;
          st    = cyc;
          ma    = in_addr;
          md    = in_data;
          exp_d = in_data;
        end
      end
      idle_m[g] = !act && !in_valid && !acc && (req_q[g].size() == 0);
      cyc++;
    end
  end

  task automatic drain(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    #1;
    while (!(idle_m[0] && idle_m[1]) && t < 3000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check(tag, 64'(t >= 3000), 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    // Idle with no requests: the model expects ready high and all else zero.
    repeat (10) @(posedge clk);

    // Single write with default timing.
    req_q[0].push_back({2'd1, 8'hA5});
    drain("drain_single");

    // Back-to-back on instance 0; illegal address then legal writes on 1.
    gap_en = 1'b0;
    req_q[0].push_back({2'd0, 8'h3C});
    req_q[0].push_back({2'd3, 8'hFF});
    req_q[1].push_back({2'd3, 8'h11});
    req_q[1].push_back({2'd2, 8'h5A});
    req_q[1].push_back({2'd0, 8'h11});
    drain("drain_directed");

    // Randomized traffic with idle gaps.
    gap_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      req_q[0].push_back({AW'($urandom_range(0, 3)), DW'($urandom)});
      req_q[1].push_back({AW'($urandom_range(0, 3)), DW'($urandom)});
    end
    drain("drain_random");

    // Reset while instance 0 has its enable open.
    gap_en = 1'b0;
    req_q[0].push_back({2'd2, 8'h77});
    t = 0;
    @(negedge clk);
    #1;
    while (!open_m[0] && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("open_wait_timeout", 64'(t >= 50), 64'd0);
    rst_n = 1'b0;
    #1;
    check("rst_async_lat_en", 64'(g_inst[0].lat_en), 64'd0);
    check("rst_async_shadow", 64'(g_inst[0].shadow), 64'd0);
    check("rst_async_ready",  64'(g_inst[0].in_ready), 64'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Traffic after reset.
    gap_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      req_q[0].push_back({AW'($urandom_range(0, 3)), DW'($urandom)});
      req_q[1].push_back({AW'($urandom_range(0, 3)), DW'($urandom)});
    end
    drain("drain_post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
